// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the BCD stopwatch controller and its decade cells.
package bcd_ctrl_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sw_state_e;

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD decade: counts 0..9 when enabled, carry is high when it is about to wrap.
module bcd_digit_cell
  import bcd_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] digit_nxt,
  output logic             carry
);

  // Values above 9 are folded back to 0 so the digit can never leave 0..9.
  always_comb begin
    digit_nxt = digit;
    if (clr) begin
      digit_nxt = '0;
    end else if (en) begin
      digit_nxt = (digit >= BCD_MAX) ? '0 : digit + 4'd1;
    end
  end

  assign carry = en && (digit == BCD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= '0;
    end else begin
      digit <= digit_nxt;
    end
  end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/stop sequencer with prescaled tick, BCD decade chain and optional limit.
// Lap capture is built only when BCD_STOPWATCH_LAP_EN is defined.
module bcd_stopwatch_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic [BCD_W*DIGITS-1:0] limit_bcd,
  input  logic                    lap,
  output logic [BCD_W*DIGITS-1:0] count_bcd,
  output logic [BCD_W*DIGITS-1:0] lap_bcd,
  output logic                    tick,
  output logic                    running,
  output logic                    done,
  output logic                    overflow
);

  localparam int CW = BCD_W * DIGITS;
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  sw_state_e     state, state_nxt;
  logic [PW-1:0] presc;
  logic [CW-1:0] limit_q;
  logic [CW-1:0] count_nxt;
  logic          overflow_q;
  logic          start_eff, stop_eff;
  logic          tick_i, chain_clr, limit_hit;
  logic [DIGITS:0] en_chain;

  // clear outranks stop, which outranks start
  assign stop_eff  = stop && !clear;
  assign start_eff = start && !stop && !clear;
  assign tick_i    = (state == RUN) && (presc == PRE_MAX) && !clear;
  assign chain_clr = clear || (start_eff && ((state == IDLE) || (state == DONE)));
  assign limit_hit = tick_i && (limit_q != '0) && (count_nxt == limit_q);

  assign en_chain[0] = tick_i;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .clr       (chain_clr),
      .en        (en_chain[i]),
      .digit     (count_bcd[BCD_W*i +: BCD_W]),
      .digit_nxt (count_nxt[BCD_W*i +: BCD_W]),
      .carry     (en_chain[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start_eff) state_nxt = RUN;
        RUN: begin
          if (limit_hit)     state_nxt = DONE;
          else if (stop_eff) state_nxt = PAUSE;
        end
        PAUSE:   if (start_eff) state_nxt = RUN;
        DONE:    if (start_eff) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    running = (state == RUN);
    done    = (state == DONE);
    tick    = tick_i;
  end

  // A stop without a coincident tick freezes the prescaler so resume keeps the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      limit_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      presc      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (en_chain[DIGITS]) overflow_q <= 1'b1;
      unique case (state)
        IDLE, DONE: begin
          if (start_eff) begin
            presc   <= '0;
            limit_q <= limit_bcd;
          end
        end
        RUN: begin
          if (tick_i)         presc <= '0;
          else if (!stop_eff) presc <= presc + PW'(1);
        end
        default: ;
      endcase
    end
  end

  assign overflow = overflow_q;

`ifdef BCD_STOPWATCH_LAP_EN
  logic [CW-1:0] lap_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lap_q <= '0;
    end else if (lap && ((state == RUN) || (state == PAUSE))) begin
      lap_q <= count_bcd;
    end
  end

  assign lap_bcd = lap_q;
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign lap_bcd    = '0;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed self-checking bench for bcd_stopwatch_ctrl (4 digits/prescale 4, plus 2 digits/prescale 2).
module tb_bcd_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, clear, lap;
  logic [15:0] limit_bcd, count_bcd, lap_bcd;
  logic        tick, running, done, overflow;

  logic        start2, stop2, clear2, lap2;
  logic [7:0]  limit2, count2, lap2_bcd;
  logic        tick2, running2, done2, overflow2;

  int n_chk = 0;
  int n_err = 0;

`ifdef BCD_STOPWATCH_LAP_EN
  localparam logic [15:0] LAP_AT7 = 16'h0007;
  localparam logic [15:0] LAP_AT8 = 16'h0008;
`else
  localparam logic [15:0] LAP_AT7 = 16'h0000;
  localparam logic [15:0] LAP_AT8 = 16'h0000;
`endif

  bcd_stopwatch_ctrl #(.DIGITS(4), .PRESCALE(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .limit_bcd(limit_bcd), .lap(lap), .count_bcd(count_bcd), .lap_bcd(lap_bcd),
    .tick(tick), .running(running), .done(done), .overflow(overflow)
  );

  bcd_stopwatch_ctrl #(.DIGITS(2), .PRESCALE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2), .clear(clear2),
    .limit_bcd(limit2), .lap(lap2), .count_bcd(count2), .lap_bcd(lap2_bcd),
    .tick(tick2), .running(running2), .done(done2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [15:0] lim);
    limit_bcd = lim;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {start, stop, clear, lap} = '0;
    {start2, stop2, clear2, lap2} = '0;
    limit_bcd = '0;
    limit2 = '0;
    step(2);
    chk("rst_count", count_bcd, 16'h0000);
    chk("rst_lap", lap_bcd, 16'h0000);
    chk("rst_flags", {tick, running, done, overflow}, 4'b0000);
    rst = 1'b0;
    step();

    // Free-run: tick every 4th cycle, 10 ticks -> 0010
    do_start(16'h0000);
    for (int i = 0; i < 40; i++) begin
      chk("fr_tick", tick, (i % 4) == 3);
      chk("fr_run_done", {running, done}, 2'b10);
      step();
    end
    chk("fr_count", count_bcd, 16'h0010);

    // Limit 0012 reached on the 12th tick
    do_clear();
    chk("clr_count", count_bcd, 16'h0000);
    chk("clr_running", running, 1'b0);
    do_start(16'h0012);
    step(47);
    chk("lim_pre_count", count_bcd, 16'h0011);
    chk("lim_pre_tick", tick, 1'b1);
    step();
    chk("lim_count", count_bcd, 16'h0012);
    chk("lim_flags", {running, done}, 2'b01);
    step(10);
    chk("lim_frozen", count_bcd, 16'h0012);
    chk("lim_no_tick", tick, 1'b0);
    do_start(16'h0012);
    chk("restart_count", count_bcd, 16'h0000);
    chk("restart_flags", {running, done}, 2'b10);

    // Pause two cycles into the period; resume ticks after two cycles
    step(2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("pause_running", running, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("pause_tick", tick, 1'b0);
      step();
    end
    chk("pause_count", count_bcd, 16'h0000);
    do_start(16'h0000);
    chk("resume_tick0", tick, 1'b0);
    step();
    chk("resume_tick1", tick, 1'b1);
    step();
    chk("resume_count", count_bcd, 16'h0001);

    // Stop on the terminal tick with limit 0005: DONE wins
    do_clear();
    do_start(16'h0005);
    step(19);
    chk("st_lim_tick", tick, 1'b1);
    chk("st_lim_pre", count_bcd, 16'h0004);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("st_lim_count", count_bcd, 16'h0005);
    chk("st_lim_flags", {running, done}, 2'b01);

    // Stop on a non-terminal tick: increment applied, PAUSE
    do_clear();
    do_start(16'h0000);
    step(3);
    chk("st_tick", tick, 1'b1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("st_count", count_bcd, 16'h0001);
    chk("st_flags", {running, done}, 2'b00);
    step(5);
    chk("st_hold", count_bcd, 16'h0001);

    // clear + start together from RUN
    do_start(16'h0000);
    step(2);
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    chk("cs_count", count_bcd, 16'h0000);
    chk("cs_flags", {running, done}, 2'b00);
    step(4);
    chk("cs_idle", {running, tick, count_bcd}, 18'h0);

    // Lap coincident with a tick at 0007, lap in PAUSE, clear zeroes lap
    do_start(16'h0000);
    step(31);
    chk("lap_pre_count", count_bcd, 16'h0007);
    chk("lap_pre_tick", tick, 1'b1);
    lap = 1'b1;
    step();
    lap = 1'b0;
    chk("lap_val", lap_bcd, LAP_AT7);
    chk("lap_count", count_bcd, 16'h0008);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    lap = 1'b1;
    step();
    lap = 1'b0;
    chk("lap_pause", lap_bcd, LAP_AT8);
    do_clear();
    chk("lap_clear", lap_bcd, 16'h0000);

    // rst during a tick cycle in RUN
    do_start(16'h0000);
    step(7);
    chk("rst_mid_tick", tick, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_count", count_bcd, 16'h0000);
    chk("rst_mid_flags", {tick, running, done, overflow}, 4'b0000);
    step(4);
    chk("rst_mid_idle", count_bcd, 16'h0000);

    // 2-digit wrap: 99 -> 00 sets sticky overflow
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    step(198);
    chk("wr_99", count2, 8'h99);
    chk("wr_ovf_pre", overflow2, 1'b0);
    step(2);
    chk("wr_00", count2, 8'h00);
    chk("wr_ovf", overflow2, 1'b1);
    chk("wr_running", running2, 1'b1);
    step(10);
    chk("wr_05", count2, 8'h05);
    chk("wr_ovf_sticky", overflow2, 1'b1);
    clear2 = 1'b1;
    step();
    clear2 = 1'b0;
    chk("wr_clr", {overflow2, running2, count2}, 10'h0);

    // Limit with a non-BCD digit never matches
    limit2 = 8'h0A;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    step(30);
    chk("bad_lim_count", count2, 8'h15);
    chk("bad_lim_flags", {running2, done2}, 2'b10);
    chk("lap2_const", lap2_bcd, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
